hawk_pg_wr_sched: RTL
=====================

Name: hawk_pg_wr_sched

Overview:
- Scheduler in front of the hawk page writer.
- Accepts whole-page write jobs from NUM_REQ requesters (e.g. zero-page fill, compressed-page copy, list-manager metadata page) and grants one job at a time by round-robin.
- Splits each granted page into fixed-size burst commands for the page writer.
- Tracks per-burst write acks, enforces an outstanding-burst limit, and signals completion to the owning requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 48, byte address width
- PAGE_BYTES, 4096, page size; power of two
- BURST_BYTES, 64, bytes per burst command; power of two, divides PAGE_BYTES
- MAX_OUTST, 4, max issued-but-unacked bursts (1..15)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester job request
- req_ready_o  out  NUM_REQ  one-hot job accept
- req_addr_i  in  NUM_REQ*ADDR_W  page base address per requester; slice i = bits [i*ADDR_W +: ADDR_W]
- req_zero_i  in  NUM_REQ  1 = zero-fill page, 0 = data copy
- cmd_valid_o  out  1  burst command valid
- cmd_ready_i  in  1  page writer accepts command
- cmd_addr_o  out  ADDR_W  burst byte address
- cmd_zero_o  out  1  zero-fill flag of current job
- cmd_id_o  out  $clog2(NUM_REQ)  owner index of current job
- cmd_last_o  out  1  last burst of page
- wr_ack_i  in  1  one-cycle pulse per completed burst from page writer
- done_valid_o  out  1  one-cycle job-complete pulse
- done_id_o  out  $clog2(NUM_REQ)  owner of completed job
- busy_o  out  1  job in progress
- err_o  out  1  sticky: ack received with zero outstanding

Behaviour:
- Reset (rst_ni low at a clock edge) clears all state.
  - All outputs 0.
  - RR pointer = NUM_REQ-1, so index 0 wins first.
  - State IDLE, counters 0.
  - Reset mid-job abandons the job: no done pulse, outstanding bursts forgotten.
- NBURST = PAGE_BYTES/BURST_BYTES.
- Counters:
  - issue_cnt and ack_cnt are $clog2(NBURST)+1 bits.
  - outst counter is $clog2(MAX_OUTST+1) bits.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - If any req_valid_i is set, grant the first set index after the RR pointer (circular).
  - Drive req_ready_o one-hot for that single cycle.
  - Latch the owner's address with its low log2(PAGE_BYTES) bits forced to 0, plus its zero flag and id.
  - Update RR pointer to the granted index. Go to ISSUE.
  - Requesters must hold valid and payload until ready.
- ISSUE:
  - cmd_valid_o = 1 while outst < MAX_OUTST; 0 at the limit (stall).
  - cmd_addr_o = base + issue_cnt*BURST_BYTES.
  - cmd_last_o = (issue_cnt == NBURST-1).
  - On cmd_valid_o & cmd_ready_i: issue_cnt++, outst++.
  - After the last handshake go to DRAIN.
  - cmd payload is stable while cmd_valid_o is high and not accepted.
- Ack handling (ISSUE or DRAIN):
  - wr_ack_i with outst > 0: outst--, ack_cnt++.
  - Simultaneous handshake and ack in one cycle: outst unchanged, both counters advance.
  - wr_ack_i with outst == 0 (including IDLE): ignored and err_o set. err_o clears only on reset.
- DRAIN:
  - When ack_cnt reaches NBURST, pulse done_valid_o/done_id_o for one cycle and return to IDLE.
  - The next grant happens no earlier than the cycle after the done pulse.
- busy_o = state != IDLE.
- Latency:
  - Grant cycle T → first cmd_valid_o at T+1.
  - Final ack at cycle A → done_valid_o at A+1.

Optional Feature:
- Macro HAWK_PGWR_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; RR pointer not implemented.
- Undefined: round-robin as above.

Test Plan:
- Single job, req0, addr 0x1000_0FFF, zero=1, cmd_ready_i tied 1, ack 2 cycles after each command:
  - grant at T; 64 commands at 0x1000_0000..0x1000_0FC0.
  - cmd_last_o only on 0x1000_0FC0.
  - done_valid_o with id 0 one cycle after the 64th ack; err_o stays 0.
- Requesters 0, 1, 2 all valid continuously for three jobs:
  - grant order 0,1,2 (RR); under HAWK_PGWR_FIXED_PRIO_EN, order 0,0,0 while req0 remains valid.
- Acks withheld:
  - exactly 4 commands issued, then cmd_valid_o = 0.
  - One ack → exactly one further command next cycle.
- cmd_ready_i low for 5 cycles mid-page:
  - cmd_valid_o held with stable cmd_addr_o.
  - No duplicate or skipped address.
- wr_ack_i pulse while IDLE → err_o = 1 and stays 1; a subsequent job completes normally.
- rst_ni low for one cycle after 10 bursts issued:
  - all outputs 0, no done_valid_o.
  - A new job restarts at its page base.

Source files
------------

// File: rtl/hawk_pg_wr_sched.sv
`default_nettype none
// hawk_pg_wr_sched (rev 1.0): grants whole-page write jobs and splits them into burst commands
// with an outstanding-burst limit. Define HAWK_PGWR_FIXED_PRIO_EN for fixed lowest-index priority.
module hawk_pg_wr_sched #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 48,
  parameter int PAGE_BYTES  = 4096,
  parameter int BURST_BYTES = 64,
  parameter int MAX_OUTST   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr_i,
  input  logic [NUM_REQ-1:0]           req_zero_i,
  output logic                         cmd_valid_o,
  input  logic                         cmd_ready_i,
  output logic [ADDR_W-1:0]            cmd_addr_o,
  output logic                         cmd_zero_o,
  output logic [$clog2(NUM_REQ)-1:0]   cmd_id_o,
  output logic                         cmd_last_o,
  input  logic                         wr_ack_i,
  output logic                         done_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]   done_id_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int NBURST = PAGE_BYTES / BURST_BYTES;
  localparam int CW     = $clog2(NBURST) + 1;
  localparam int OW     = $clog2(MAX_OUTST + 1);
  localparam int IW     = $clog2(NUM_REQ);
  localparam int BO     = $clog2(BURST_BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     gnt_idx, id;
  logic              gnt_found, zero, err, hs, ack_ok;
  logic [ADDR_W-1:0] base, sel_addr;
  logic [CW-1:0]     issue_cnt, ack_cnt;
  logic [OW-1:0]     outst;

`ifdef HAWK_PGWR_FIXED_PRIO_EN
  always_comb begin : p_arb
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin : p_arb
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end
`endif

  assign sel_addr = req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign hs       = cmd_valid_o & cmd_ready_i;
  assign ack_ok   = wr_ack_i & (outst != '0);

  always_comb begin : p_fsm
    state_n      = state;
    req_ready_o  = '0;
    cmd_valid_o  = 1'b0;
    done_valid_o = 1'b0;
    if (rst_ni) begin
      unique case (state)
        IDLE: begin
          if (gnt_found) begin
            req_ready_o = NUM_REQ'(1) << gnt_idx;
            state_n     = ISSUE;
          end
        end
        ISSUE: begin
          cmd_valid_o = (outst < OW'(MAX_OUTST));
          if (cmd_valid_o && cmd_ready_i && cmd_last_o) state_n = DRAIN;
        end
        DRAIN: begin
          if (ack_cnt == CW'(NBURST)) begin
            done_valid_o = 1'b1;
            state_n      = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      base      <= '0;
      zero      <= 1'b0;
      id        <= '0;
      issue_cnt <= '0;
      ack_cnt   <= '0;
      outst     <= '0;
      err       <= 1'b0;
`ifndef HAWK_PGWR_FIXED_PRIO_EN
      rr_ptr    <= IW'(NUM_REQ - 1);
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && gnt_found) begin
        base      <= sel_addr & ~ADDR_W'(PAGE_BYTES - 1);
        zero      <= req_zero_i[gnt_idx];
        id        <= gnt_idx;
        issue_cnt <= '0;
        ack_cnt   <= '0;
`ifndef HAWK_PGWR_FIXED_PRIO_EN
        rr_ptr    <= gnt_idx;
`endif
      end else begin
        if (hs)     issue_cnt <= issue_cnt + CW'(1);
        if (ack_ok) ack_cnt   <= ack_cnt + CW'(1);
      end
      outst <= outst + OW'(hs) - OW'(ack_ok);
      // An ack with nothing outstanding is a protocol error on the writer side.
      if (wr_ack_i && outst == '0) err <= 1'b1;
    end
  end

  assign cmd_addr_o = base + (ADDR_W'(issue_cnt) << BO);
  assign cmd_last_o = (state == ISSUE) && (issue_cnt == CW'(NBURST - 1));
  assign cmd_zero_o = zero;
  assign cmd_id_o   = id;
  assign done_id_o  = done_valid_o ? id : '0;
  assign busy_o     = rst_ni & (state != IDLE);
  assign err_o      = err;

endmodule
`default_nettype wire
